log_unit: RTL

Parametrised, handshaked fixed-point logarithm unit for the discrete-audio math library. It generalises the single-function natural-log core in four ways: selectable base (log2, ln, log10), parametrised input/output widths and fraction bits, correct signed results for inputs below 1.0, and an explicit zero-input error path. It sits between a component-value stage (e.g. a diode/transistor current model) and exponential-domain mixing logic, and accepts one operand at a time through a ready/valid handshake.

---
 rtl/log_unit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/log_unit.sv
// log_unit: handshaked fixed-point logarithm (log2 / ln / log10).
// MSB normalisation gives the integer part, repeated mantissa squaring gives the fraction.
module log_unit #(
  parameter int IN_WIDTH  = 24,
  parameter int IN_FRAC   = 8,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_FRAC  = 8,
  parameter int G         = OUT_FRAC + 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_err
);
  localparam int PW   = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int IW   = PW + 2;
  localparam int LW   = IW + G;
  localparam int PWID = LW + 18;
  localparam int CW   = $clog2(G + 1);
  localparam int SH   = 16 + G - OUT_FRAC;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_NORM  = 3'd1;
  localparam logic [2:0] S_ITER  = 3'd2;
  localparam logic [2:0] S_SCALE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [IN_WIDTH-1:0]  x_q, x_d;
  logic [1:0]           mode_q, mode_d;
  logic [IW-1:0]        int_q, int_d;
  logic [16:0]          m_q, m_d;
  logic [G-1:0]         frac_q, frac_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_err_q, out_err_d;

  logic [PW-1:0]          msb_pos;
  logic [33:0]            m_sq;
  logic [16:0]            k_sel;
  logic signed [LW-1:0]   l_val;
  logic signed [PWID-1:0] prod;
  logic signed [PWID-1:0] y_full;
  logic [OUT_WIDTH-1:0]   y_sat;

  always_comb begin
    msb_pos = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (x_q[i]) msb_pos = PW'(i);
    end
  end

  assign m_sq = {17'b0, m_q} * {17'b0, m_q};

  always_comb begin
    case (mode_q)
      2'd1:    k_sel = 17'd45426;
      2'd2:    k_sel = 17'd19728;
      default: k_sel = 17'd65536;
    endcase
  end

  assign l_val  = {int_q, frac_q};
  assign prod   = PWID'(l_val) * PWID'($signed({1'b0, k_sel}));
  assign y_full = prod >>> SH;

  // Result fits when every bit above the output sign bit matches it.
  always_comb begin
    if ((y_full[PWID-1:OUT_WIDTH-1] == '0) || (y_full[PWID-1:OUT_WIDTH-1] == '1)) begin
      y_sat = y_full[OUT_WIDTH-1:0];
    end else if (y_full[PWID-1]) begin
      y_sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      y_sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    mode_d      = mode_q;
    int_d       = int_q;
    m_d         = m_q;
    frac_d      = frac_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = in_data;
          mode_d  = in_mode;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        int_d   = IW'(int'(msb_pos) - IN_FRAC);
        m_d     = 17'(({x_q, 17'b0} << (IN_WIDTH - 1 - int'(msb_pos))) >> IN_WIDTH);
        frac_d  = '0;
        cnt_d   = '0;
        err_d   = (x_q == '0);
        state_d = (x_q == '0) ? S_SCALE : S_ITER;
      end
      S_ITER: begin
        // Squaring doubles log2(m); crossing 2.0 yields the next fraction bit.
        frac_d = {frac_q[G-2:0], m_sq[33]};
        m_d    = 17'(m_sq >> (m_sq[33] ? 17 : 16));
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(G - 1)) state_d = S_SCALE;
      end
      S_SCALE: begin
        out_valid_d = 1'b1;
        out_err_d   = err_q;
        out_data_d  = err_q ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : y_sat;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      mode_q      <= '0;
      int_q       <= '0;
      m_q         <= '0;
      frac_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      mode_q      <= mode_d;
      int_q       <= int_d;
      m_q         <= m_d;
      frac_q      <= frac_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
endmodule
